// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module : led_pkg
// Brief  : Shared LED demo types and constants (modes, direction, polarity).
// Rev    : 1.0 - initial release
// ============================================================================
package led_pkg;

  typedef enum logic [1:0] {
    LED_MODE_SHL    = 2'b00,
    LED_MODE_SHR    = 2'b01,
    LED_MODE_BOUNCE = 2'b10,
    LED_MODE_FILL   = 2'b11
  } led_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } led_dir_e;

  localparam logic LED_ON   = 1'b0;
  localparam int   SYS_FREQ = 12_000_000;

endpackage
`default_nettype wire

// File: rtl/led_step_timer.sv
`default_nettype none
// ============================================================================
// Module : led_step_timer
// Brief  : Prescaler counting 0..STEP_CYCLES-1 while running; otick on wrap.
// Rev    : 1.0 - initial release
// ============================================================================
module led_step_timer #(
  parameter int STEP_CYCLES = 12_000_000
) (
  input  logic iclk,
  input  logic irst_n,
  input  logic irun,
  input  logic iclr,
  output logic otick
);

  localparam int            CW     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign otick = irun && (r_cnt == c_LAST);

  // A clear overrides a coincident tick so the new interval starts from zero.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_cnt <= '0;
    end else if (iclr) begin
      r_cnt <= '0;
    end else if (otick) begin
      r_cnt <= '0;
    end else if (irun) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_fsm.sv
`default_nettype none
// ============================================================================
// Module : led_pattern_fsm
// Brief  : N-LED active-low animation generator (shift L/R, bounce, bar-fill).
// Rev    : 1.0 - initial release
// ============================================================================
module led_pattern_fsm
  import led_pkg::*;
#(
  parameter int LED_NUM     = 8,
  parameter int STEP_CYCLES = SYS_FREQ
) (
  input  logic                         iclk,
  input  logic                         irst_n,
  input  logic                         irun,
  input  logic [1:0]                   ivmode,
  output logic [LED_NUM-1:0]           owvled,
  output logic                         owstep,
  output logic [$clog2(LED_NUM+1)-1:0] owvpos
);

  localparam int            PW        = $clog2(LED_NUM + 1);
  localparam logic [PW-1:0] c_LAST    = PW'(LED_NUM - 1);
  localparam logic [PW-1:0] c_PENULT  = PW'(LED_NUM - 2);
  localparam logic [PW-1:0] c_FULL    = PW'(LED_NUM);

  function automatic logic [LED_NUM-1:0] led_decode(input led_mode_e m,
                                                    input logic [PW-1:0] p);
    logic [LED_NUM-1:0] v;
    logic               lit;
    logic [31:0]        pp;
    v  = '1;
    pp = 32'(p);
    for (int i = 0; i < LED_NUM; i++) begin
      lit = 1'b0;
      case (m)
        LED_MODE_SHL:    lit = (32'(i) == pp);
        LED_MODE_SHR:    lit = (32'(LED_NUM - 1 - i) == pp);
        LED_MODE_BOUNCE: lit = (32'(i) == pp);
        LED_MODE_FILL:   lit = (32'(i) < pp);
      endcase
      v[i] = lit ? LED_ON : ~LED_ON;
    end
    return v;
  endfunction

  localparam logic [LED_NUM-1:0] c_RESET_LED = led_decode(LED_MODE_SHL, '0);

  led_mode_e          r_mode, w_mode_nxt;
  led_dir_e           r_dir,  w_dir_nxt;
  logic [PW-1:0]      r_pos,  w_pos_nxt;
  logic [LED_NUM-1:0] w_led_nxt;
  logic               w_restart;
  logic               w_tick;

  assign w_restart = (ivmode != r_mode);

  led_step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_timer (
    .iclk   (iclk),
    .irst_n (irst_n),
    .irun   (irun),
    .iclr   (w_restart),
    .otick  (w_tick)
  );

  // Bounce flips direction on arrival at an end so each end is shown once.
  always_comb begin
    w_mode_nxt = r_mode;
    w_dir_nxt  = r_dir;
    w_pos_nxt  = r_pos;
    if (w_restart) begin
      w_mode_nxt = led_mode_e'(ivmode);
      w_dir_nxt  = DIR_UP;
      w_pos_nxt  = '0;
    end else if (w_tick) begin
      case (r_mode)
        LED_MODE_SHL, LED_MODE_SHR: begin
          w_pos_nxt = (r_pos == c_LAST) ? '0 : r_pos + PW'(1);
        end
        LED_MODE_BOUNCE: begin
          if (r_dir == DIR_UP) begin
            w_pos_nxt = r_pos + PW'(1);
            if (r_pos == c_PENULT) w_dir_nxt = DIR_DOWN;
          end else begin
            w_pos_nxt = r_pos - PW'(1);
            if (r_pos == PW'(1)) w_dir_nxt = DIR_UP;
          end
        end
        LED_MODE_FILL: begin
          w_pos_nxt = (r_pos == c_FULL) ? '0 : r_pos + PW'(1);
        end
      endcase
    end
    w_led_nxt = led_decode(w_mode_nxt, w_pos_nxt);
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_mode <= LED_MODE_SHL;
      r_dir  <= DIR_UP;
      r_pos  <= '0;
      owvled <= c_RESET_LED;
      owstep <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_dir  <= w_dir_nxt;
      r_pos  <= w_pos_nxt;
      owvled <= w_led_nxt;
      owstep <= w_tick && !w_restart;
    end
  end

  assign owvpos = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_fsm.sv
`default_nettype none
// ============================================================================
// Module : tb_led_pattern_fsm
// Brief  : Directed self-checking bench, LED_NUM=8, STEP_CYCLES=4.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_fsm;

  logic       iclk;
  logic       irst_n;
  logic       irun;
  logic [1:0] ivmode;
  logic [7:0] owvled;
  logic       owstep;
  logic [3:0] owvpos;

  int n_checks = 0;
  int n_fail   = 0;

  led_pattern_fsm #(
    .LED_NUM     (8),
    .STEP_CYCLES (4)
  ) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .irun   (irun),
    .ivmode (ivmode),
    .owvled (owvled),
    .owstep (owstep),
    .owvpos (owvpos)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Counts negedges until owstep is seen high (bounded).
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge iclk);
      n++;
    end while (!owstep && n < 20);
  endtask

  task automatic test_reset();
    irst_n = 1'b0; irun = 1'b0; ivmode = 2'b00;
    repeat (3) @(negedge iclk);
    n_checks++;
    if (owvled !== 8'hFE || owstep !== 1'b0 || owvpos !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: led=%h step=%b pos=%0d, want FE/0/0", owvled, owstep, owvpos);
    end
    irst_n = 1'b1; irun = 1'b1;
  endtask

  task automatic test_shift_left();
    int n;
    logic [7:0] e;
    for (int k = 1; k <= 9; k++) begin
      wait_step(n);
      e = ~(8'h01 << (k % 8));
      n_checks++;
      if (n !== 4 || owvled !== e || owvpos !== 4'(k % 8)) begin
        n_fail++;
        $display("FAIL shl step %0d: gap=%0d led=%h pos=%0d, want 4/%h/%0d", k, n, owvled, owvpos, e, k % 8);
      end
    end
  endtask

  task automatic test_bounce();
    int n;
    int seq [16] = '{1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2};
    logic [7:0] e;
    ivmode = 2'b10;
    @(negedge iclk);
    n_checks++;
    if (owvled !== 8'hFE || owvpos !== 4'd0 || owstep !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce restart: led=%h pos=%0d step=%b, want FE/0/0", owvled, owvpos, owstep);
    end
    for (int k = 0; k < 16; k++) begin
      wait_step(n);
      e = ~(8'h01 << seq[k]);
      n_checks++;
      if (n !== 4 || owvpos !== 4'(seq[k]) || owvled !== e) begin
        n_fail++;
        $display("FAIL bounce step %0d: gap=%0d pos=%0d led=%h, want 4/%0d/%h", k, n, owvpos, owvled, seq[k], e);
      end
    end
  endtask

  task automatic test_fill();
    int n;
    int lvl;
    logic [8:0] m;
    logic [7:0] e;
    ivmode = 2'b11;
    @(negedge iclk);
    n_checks++;
    if (owvled !== 8'hFF || owvpos !== 4'd0) begin
      n_fail++;
      $display("FAIL fill restart: led=%h pos=%0d, want FF/0", owvled, owvpos);
    end
    for (int k = 1; k <= 10; k++) begin
      wait_step(n);
      lvl = k % 9;
      m = (9'd1 << lvl) - 9'd1;
      e = ~m[7:0];
      n_checks++;
      if (n !== 4 || owvled !== e || owvpos !== 4'(lvl)) begin
        n_fail++;
        $display("FAIL fill step %0d: gap=%0d led=%h pos=%0d, want 4/%h/%0d", k, n, owvled, owvpos, e, lvl);
      end
    end
  endtask

  task automatic test_freeze();
    int n;
    logic seen_step;
    ivmode = 2'b00;
    @(negedge iclk);
    repeat (2) @(negedge iclk);
    irun = 1'b0;
    seen_step = 1'b0;
    repeat (10) begin
      @(negedge iclk);
      if (owstep) seen_step = 1'b1;
    end
    n_checks++;
    if (owvled !== 8'hFE || seen_step !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze: led=%h stepped=%b, want FE/0", owvled, seen_step);
    end
    irun = 1'b1;
    wait_step(n);
    n_checks++;
    if (n !== 2 || owvled !== 8'hFD) begin
      n_fail++;
      $display("FAIL resume: gap=%0d led=%h, want 2/FD", n, owvled);
    end
  endtask

  task automatic test_mode_on_tick();
    int n;
    repeat (3) @(negedge iclk);
    ivmode = 2'b01;
    @(negedge iclk);
    n_checks++;
    if (owvled !== 8'h7F || owvpos !== 4'd0 || owstep !== 1'b0) begin
      n_fail++;
      $display("FAIL switch on tick: led=%h pos=%0d step=%b, want 7F/0/0", owvled, owvpos, owstep);
    end
    wait_step(n);
    n_checks++;
    if (n !== 4 || owvled !== 8'hBF || owvpos !== 4'd1) begin
      n_fail++;
      $display("FAIL shr first step: gap=%0d led=%h pos=%0d, want 4/BF/1", n, owvled, owvpos);
    end
  endtask

  task automatic test_async_reset();
    int n;
    ivmode = 2'b10;
    @(negedge iclk);
    repeat (6) @(negedge iclk);
    #2 irst_n = 1'b0;
    #1;
    n_checks++;
    if (owvled !== 8'hFE || owvpos !== 4'd0 || owstep !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset: led=%h pos=%0d step=%b, want FE/0/0", owvled, owvpos, owstep);
    end
    ivmode = 2'b00;
    @(negedge iclk);
    irst_n = 1'b1;
    wait_step(n);
    n_checks++;
    if (n !== 4 || owvled !== 8'hFD || owvpos !== 4'd1) begin
      n_fail++;
      $display("FAIL after reset step: gap=%0d led=%h pos=%0d, want 4/FD/1", n, owvled, owvpos);
    end
  endtask

  task automatic test_release_restart();
    int n;
    irst_n = 1'b0;
    ivmode = 2'b01;
    @(negedge iclk);
    irst_n = 1'b1;
    @(negedge iclk);
    n_checks++;
    if (owvled !== 8'h7F || owvpos !== 4'd0 || owstep !== 1'b0) begin
      n_fail++;
      $display("FAIL release restart: led=%h pos=%0d step=%b, want 7F/0/0", owvled, owvpos, owstep);
    end
    wait_step(n);
    n_checks++;
    if (n !== 4 || owvled !== 8'hBF) begin
      n_fail++;
      $display("FAIL release step: gap=%0d led=%h, want 4/BF", n, owvled);
    end
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_bounce();
    test_fill();
    test_freeze();
    test_mode_on_tick();
    test_async_reset();
    test_release_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pattern_fsm.md
# led_pattern_fsm

Parametrised LED pattern generator: drives an N-bit active-low LED bank with a selectable animation (shift left, shift right, bounce, bar-fill), advancing one step per programmable number of clocks. It is the generalised successor of the fixed 8-LED one-hot chaser. It sits between the board top level and the LED pins and takes mode and run controls from switches or a host register.

## Interface
- `LED_NUM`, default 8: number of LEDs, legal range 2..32.
- `STEP_CYCLES`, default 12_000_000: clocks per animation step (1 s at 12 MHz), legal ≥1.
- `iclk` input, 1 bit: system clock.
- `irst_n` input, 1 bit: reset, asynchronous, active-low; clock `iclk`.
- `irun` input, 1 bit: 1 = animate, 0 = freeze the pattern and the prescaler.
- `ivmode` input, 2 bits: 00 shift-left, 01 shift-right, 10 bounce, 11 bar-fill.
- `owvled` output, `LED_NUM` bits: LED drive, registered, active-low (0 = lit).
- `owstep` output, 1 bit: one-cycle pulse, high in the first cycle a new pattern is shown.
- `owvpos` output, `$clog2(LED_NUM+1)` bits: current position/level, registered.

## Operation
- Prescaler `cnt` counts 0..`STEP_CYCLES`-1 while `irun`=1 and holds while `irun`=0.
- `tick` = `irun` && `cnt`==`STEP_CYCLES`-1. On `tick`, `cnt` wraps to 0.
- The mode register `mode_q` latches `ivmode`. When `ivmode`≠`mode_q` on an edge:
  - `mode_q`←`ivmode`, `pos`←0, `dir`←up, `cnt`←0.
  - `owvled`←the initial pattern of the new mode.
  - `owstep`←0.
  - This restart takes priority over `tick`, so no step happens on that edge.
- Each mode on `tick`:
  - Shift-left: `pos` = (`pos`+1) mod `LED_NUM`. Lit bit = `pos`.
  - Shift-right: `pos` = (`pos`+1) mod `LED_NUM`. Lit bit = `LED_NUM`-1-`pos`.
  - Bounce: `pos` goes up to `LED_NUM`-1, then `dir` flips and it goes down to 0, then flips again. The end LEDs are each shown once per pass. Period = 2·(`LED_NUM`-1) steps. Lit bit = `pos`.
  - Bar-fill: level `pos` = 0..`LED_NUM`. Bits [`pos`-1:0] are lit. After `LED_NUM` (all lit) the level returns to 0 (all dark). Period = `LED_NUM`+1 steps.
- Initial patterns at `pos`=0:
  - Shift-left: bit0 lit.
  - Shift-right: bit `LED_NUM`-1 lit.
  - Bounce: bit0 lit.
  - Bar-fill: all dark.
- Unlit bits are always 1. Exactly one bit is 0 in modes 00, 01 and 10.

## Timing
- Reset values:
  - `mode_q`=00, `pos`=0, `dir`=up, `cnt`=0.
  - `owvled`=all 1 except bit0=0.
  - `owstep`=0, `owvpos`=0.
- If `ivmode`≠00 at reset release, the first clock edge performs a mode restart.
- `pos`, `owvled` and `owvpos` all update on the same edge where `tick`=1. `owstep` is high for exactly the following cycle.
- Step interval with `irun` held at 1 is exactly `STEP_CYCLES` clocks. With `STEP_CYCLES`=1, the pattern steps every cycle.
- `irun` going low freezes `cnt`. Raising it again resumes the count from the frozen value; the count is not restarted.
- Reset asserted mid-step returns all state to the reset values immediately (asynchronously).
- All arithmetic is unsigned. `cnt` width is max(1, `$clog2(STEP_CYCLES)`). No combinational path from inputs to outputs.

## Structure
- Shared package `led_pkg`:
  - Mode constants `LED_MODE_SHL`, `LED_MODE_SHR`, `LED_MODE_BOUNCE`, `LED_MODE_FILL`.
  - Constant `LED_ON`=1'b0.
  - Default `SYS_FREQ`=12_000_000.
- Sub-module `led_step_timer`: prescaler with parameter `STEP_CYCLES`, inputs `iclk`, `irst_n`, `irun`, `iclr`, output `otick`. It is reusable by other board demos.
- The top holds `mode_q`, `pos`, `dir`, the pattern decode and the output registers.

## Test plan
Bench parameters: `LED_NUM`=8, `STEP_CYCLES`=4.
1. Reset, mode 00, `irun`=1 → `owvled` goes FE, FD, FB … 7F, FE, with changes every 4 clocks and `owstep` pulsing with each change.
2. Mode 10 for 16 steps → `owvpos` goes 0,1..7,6..1,0,1,2. No repeated 7 or 0 at the turns.
3. Mode 11 → `owvled` goes FF, FE, FC … 00, FF. Period is 9 steps.
4. `irun`=0 for 10 clocks after 2 clocks of counting → pattern frozen. The next step comes 2 clocks after `irun` returns to 1.
5. Switch `ivmode` 00→01 on the same edge as a `tick` → `owvled`=7F, `owvpos`=0, `owstep`=0. The next step comes 4 clocks later and gives BF.
6. Assert `irst_n` low mid-count in mode 10 → outputs are FE/0/0 immediately. After release, the first step comes 4 clocks later.
